// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: two valid/ready writeback requesters
// share one registered write port, round-robin on contention.
//
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   hold                 : freeze, blocks all grants
//   req0_* / req1_*      : valid, addr, data in; ready out (combinational)
//   D, DA, write         : registered register file write port
//   grant_id             : requester whose transfer is on D/DA
//   drop_count           : saturating count of accepted writes to X31
module regfile_write_arbiter #(
    parameter int N  = 64,
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          hold,
    input  logic          req0_valid,
    input  logic [4:0]    req0_addr,
    input  logic [N-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [4:0]    req1_addr,
    input  logic [N-1:0]  req1_data,
    output logic          req1_ready,
    output logic [N-1:0]  D,
    output logic [4:0]    DA,
    output logic          write,
    output logic          grant_id,
    output logic [CW-1:0] drop_count
);

    localparam logic [4:0] ZERO_REG = 5'd31;

    logic [N-1:0]  r_d;
    logic [4:0]    r_da;
    logic          r_write;
    logic          r_gid;
    logic          r_last;
    logic [CW-1:0] r_drop;

    logic          w_open;
    logic          w_rdy0;
    logic          w_rdy1;
    logic          w_grant;
    logic          w_sel;
    logic [4:0]    w_addr;
    logic [N-1:0]  w_data;
    logic          w_x31;

    // No grants while frozen or while reset is being applied.
    assign w_open = ~hold & ~reset;

    // On contention the requester other than the last winner goes first.
    assign w_rdy0 = w_open & req0_valid & (~req1_valid | r_last);
    assign w_rdy1 = w_open & req1_valid & (~req0_valid | ~r_last);

    assign w_grant = w_rdy0 | w_rdy1;
    assign w_sel   = w_rdy1;
    assign w_addr  = w_sel ? req1_addr : req0_addr;
    assign w_data  = w_sel ? req1_data : req0_data;
    assign w_x31   = (w_addr == ZERO_REG);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_d     <= '0;
            r_da    <= '0;
            r_write <= 1'b0;
            r_gid   <= 1'b0;
            r_last  <= 1'b1;
            r_drop  <= '0;
        end else if (w_grant) begin
            r_d     <= w_data;
            r_da    <= w_addr;
            r_gid   <= w_sel;
            r_last  <= w_sel;
            // X31 writes are accepted but never reach the register file.
            r_write <= ~w_x31;
            if (w_x31 && (r_drop != {CW{1'b1}})) begin
                r_drop <= r_drop + 1'b1;
            end
        end else begin
            r_write <= 1'b0;
        end
    end

    assign req0_ready = w_rdy0;
    assign req1_ready = w_rdy1;
    assign D          = r_d;
    assign DA         = r_da;
    assign write      = r_write;
    assign grant_id   = r_gid;
    assign drop_count = r_drop;

endmodule
